// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM that fetches an instruction, decodes it, and drives
// the program counter and datapath strobes. It keeps a small return-address
// stack for CALL/RET.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   run        leave IDLE and start fetching (only looked at in IDLE)
//   mem_ack    instr_in is valid this cycle
//   instr_in   opcode [15:12], target address [ADDR_W-1:0]
//   pc_val     current program counter (already incremented when CALL executes)
//   zero_flag  ALU zero flag, sampled by JZ/JNZ in EXEC
//   ex_done    datapath finished; only looked at in EX_WAIT
//   pc_en      program counter enable
//   pc_up      increment the PC
//   pc_ld      load pc_target into the PC
//   pc_target  load value; 0 whenever pc_ld=0
//   mem_req    instruction fetch request
//   ex_start   one-cycle datapath start pulse
//   halted     FSM is in HALT
//   fault      sticky stack overflow/underflow flag
//   state      encoded FSM state for debug
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              mem_ack,
  input  logic [15:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_val,
  input  logic              zero_flag,
  input  logic              ex_done,
  output logic              pc_en,
  output logic              pc_up,
  output logic              pc_ld,
  output logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic              ex_start,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_EX_WAIT = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JZ   = 4'd2;
  localparam logic [3:0] OP_JNZ  = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_RET  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;
  localparam logic [3:0] OP_SKIP = 4'd7;

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [15:0]       ir_q;
  logic [CNT_W-1:0]  sp_q, sp_d, sp_m1;
  logic              fault_q, fault_d;
  logic              push;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [IDX_W-1:0]  push_idx, top_idx;
  logic              unused_ir;

  assign opcode    = ir_q[15:12];
  assign target    = ir_q[ADDR_W-1:0];
  assign sp_m1     = sp_q - 1'b1;
  assign push_idx  = sp_q[IDX_W-1:0];
  assign top_idx   = sp_m1[IDX_W-1:0];
  assign unused_ir = ^ir_q[11:ADDR_W];

  assign state  = state_q;
  assign halted = (state_q == S_HALT);
  assign fault  = fault_q;

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    fault_d   = fault_q;
    push      = 1'b0;
    pc_en     = 1'b0;
    pc_up     = 1'b0;
    pc_ld     = 1'b0;
    pc_target = '0;
    mem_req   = 1'b0;
    ex_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        // HALT must not advance the PC, so it bypasses EXEC entirely.
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          pc_en   = 1'b1;
          pc_up   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_JMP: begin
            pc_en     = 1'b1;
            pc_ld     = 1'b1;
            pc_target = target;
          end
          OP_JZ, OP_JNZ: begin
            // JZ takes the branch on zero_flag=1, JNZ on zero_flag=0.
            if (zero_flag == (opcode == OP_JZ)) begin
              pc_en     = 1'b1;
              pc_ld     = 1'b1;
              pc_target = target;
            end
          end
          OP_CALL: begin
            if (sp_q == CNT_FULL) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              // pc_val was incremented in DECODE, so it is the return address.
              push      = 1'b1;
              sp_d      = sp_q + 1'b1;
              pc_en     = 1'b1;
              pc_ld     = 1'b1;
              pc_target = target;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              sp_d      = sp_m1;
              pc_en     = 1'b1;
              pc_ld     = 1'b1;
              pc_target = stack_q[top_idx];
            end
          end
          OP_HALT: state_d = S_HALT;
          OP_SKIP: begin
            pc_en = 1'b1;
            pc_up = 1'b1;
          end
          default: begin
            ex_start = 1'b1;
            state_d  = S_EX_WAIT;
          end
        endcase
      end
      S_EX_WAIT: begin
        if (ex_done) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
      if (state_q == S_FETCH && mem_ack) ir_q <= instr_in;
    end
  end

  // Stack contents need no reset: the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_val;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int ADDR_W = 8;
  localparam logic [1:0] K_UP  = 2'd0;
  localparam logic [1:0] K_LD  = 2'd1;
  localparam logic [1:0] K_EXS = 2'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              mem_ack = 1'b0;
  logic [15:0]       instr_in = '0;
  logic [ADDR_W-1:0] pc_val = '0;
  logic              zero_flag = 1'b0;
  logic              ex_done = 1'b0;
  logic              pc_en, pc_up, pc_ld, mem_req, ex_start, halted, fault;
  logic [ADDR_W-1:0] pc_target;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+1:0] exp_q[$];

  pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_ack(mem_ack), .instr_in(instr_in),
    .pc_val(pc_val), .zero_flag(zero_flag), .ex_done(ex_done),
    .pc_en(pc_en), .pc_up(pc_up), .pc_ld(pc_ld), .pc_target(pc_target),
    .mem_req(mem_req), .ex_start(ex_start), .halted(halted), .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  // Strobe monitor: every PC strobe / ex_start pulse pops the scoreboard.
  always @(negedge clk) begin
    logic [ADDR_W+1:0] obs, expv;
    if (!rst) begin
      checks++;
      if (pc_en || pc_up || pc_ld || mem_req || ex_start || halted || fault) begin
        errors++;
        $display("FAIL reset_quiet: en=%b up=%b ld=%b req=%b exs=%b halted=%b fault=%b want all 0",
                 pc_en, pc_up, pc_ld, mem_req, ex_start, halted, fault);
      end
    end else begin
      checks++;
      if ((pc_ld && pc_up) || (!pc_en && (pc_ld || pc_up)) || (!pc_ld && pc_target != '0)) begin
        errors++;
        $display("FAIL strobe_rules: en=%b up=%b ld=%b target=%h", pc_en, pc_up, pc_ld, pc_target);
      end
      if (pc_en || ex_start) begin
        obs = {(ex_start ? K_EXS : (pc_ld ? K_LD : K_UP)), pc_target};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got kind=%0d target=%h want none", obs[ADDR_W+1:ADDR_W], obs[ADDR_W-1:0]);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            errors++;
            $display("FAIL sb_strobe: got kind=%0d target=%h want kind=%0d target=%h",
                     obs[ADDR_W+1:ADDR_W], obs[ADDR_W-1:0], expv[ADDR_W+1:ADDR_W], expv[ADDR_W-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [2:0] want);
    checks++;
    if (state !== want) begin
      errors++;
      $display("FAIL %s: state=%0d want=%0d", name, state, want);
    end
  endtask

  task automatic sb_drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected strobes never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; mem_ack = 1'b0; ex_done = 1'b0;
    zero_flag = 1'b0; instr_in = '0; pc_val = '0;
    exp_q.delete();
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
    chk_state("run_to_fetch", 3'd1);
  endtask

  task automatic fetch(input logic [15:0] instr, input int lat, output int nreq);
    instr_in = instr;
    mem_ack = 1'b0;
    nreq = 0;
    for (int i = 0; i < lat; i++) begin
      if (mem_req) nreq++;
      tick();
    end
    mem_ack = 1'b1;
    if (mem_req) nreq++;
    tick();
    mem_ack = 1'b0;
    chk_state("fetch_to_decode", 3'd2);
  endtask

  // Fetch + DECODE (expects the PC+1 strobe), leaving the FSM in EXEC.
  task automatic issue(input logic [15:0] instr, input int lat);
    int n;
    fetch(instr, lat, n);
    exp_q.push_back({K_UP, 8'h00});
    tick();
    chk_state("decode_to_exec", 3'd3);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    chk_state("reset_state", 3'd0);
    checks++;
    if ({pc_en, pc_up, pc_ld, mem_req, ex_start, halted, fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {pc_en, pc_up, pc_ld, mem_req, ex_start, halted, fault});
    end
    do_reset();
    chk_state("reset_idle_no_run", 3'd0);
  endtask

  task automatic test_nop();
    int n;
    start_run();
    fetch(16'h0000, 2, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL nop_mem_req_cycles: got %0d want 3", n);
    end
    exp_q.push_back({K_UP, 8'h00});
    tick();
    chk_state("nop_exec", 3'd3);
    tick();
    chk_state("nop_to_fetch", 3'd1);
    sb_drain("nop_drain");
  endtask

  task automatic test_jmp();
    issue(16'h10AA, 0);
    exp_q.push_back({K_LD, 8'hAA});
    tick();
    chk_state("jmp_to_fetch", 3'd1);
    sb_drain("jmp_drain");
  endtask

  task automatic test_jz();
    zero_flag = 1'b0;
    issue(16'h2010, 1);
    tick();
    chk_state("jz_not_taken", 3'd1);
    zero_flag = 1'b1;
    issue(16'h2010, 0);
    exp_q.push_back({K_LD, 8'h10});
    tick();
    zero_flag = 1'b0;
    issue(16'h3077, 0);
    exp_q.push_back({K_LD, 8'h77});
    tick();
    chk_state("jnz_to_fetch", 3'd1);
    sb_drain("jz_drain");
  endtask

  task automatic test_call_ret();
    issue(16'h4040, 0);
    pc_val = 8'h06;
    exp_q.push_back({K_LD, 8'h40});
    tick();
    pc_val = 8'h41;
    issue(16'h5000, 0);
    exp_q.push_back({K_LD, 8'h06});
    tick();
    chk_state("ret_to_fetch", 3'd1);
    sb_drain("call_ret_drain");
  endtask

  task automatic test_skip();
    issue(16'h7000, 0);
    exp_q.push_back({K_UP, 8'h00});
    tick();
    chk_state("skip_to_fetch", 3'd1);
    sb_drain("skip_drain");
  endtask

  task automatic test_ex();
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    chk_state("ex_done_ignored", 3'd1);
    issue(16'h9000, 0);
    exp_q.push_back({K_EXS, 8'h00});
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_state("ex_wait_hold", 3'd4);
      tick();
    end
    ex_done = 1'b1;
    chk_state("ex_wait_last", 3'd4);
    tick();
    ex_done = 1'b0;
    chk_state("ex_wait_to_fetch", 3'd1);
    sb_drain("ex_drain");
    issue(16'hA000, 0);
    exp_q.push_back({K_EXS, 8'h00});
    tick();
    chk_state("ex_wait_again", 3'd4);
    #2 rst = 1'b0;
    #1;
    chk_state("rst_abandons_wait", 3'd0);
    sb_drain("ex_rst_drain");
    do_reset();
  endtask

  task automatic test_rst_fetch();
    start_run();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_mem_req: got %b want 1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL rst_drops_req: mem_req=%b state=%0d want 0/0", mem_req, state);
    end
    do_reset();
  endtask

  task automatic test_stack_full();
    logic [7:0] tgt;
    start_run();
    for (int i = 0; i < 4; i++) begin
      tgt = 8'(8'h20 + i * 16);
      issue({8'h40, tgt}, 0);
      pc_val = 8'(i + 1);
      exp_q.push_back({K_LD, tgt});
      tick();
    end
    issue(16'h4050, 0);
    tick();
    chk_state("call_full_halt", 3'd5);
    checks++;
    if (halted !== 1'b1 || fault !== 1'b1) begin
      errors++;
      $display("FAIL call_full_flags: halted=%b fault=%b want 1/1", halted, fault);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    chk_state("halt_sticky", 3'd5);
    sb_drain("call_full_drain");
    do_reset();
  endtask

  task automatic test_ret_empty();
    start_run();
    issue(16'h5000, 0);
    tick();
    chk_state("ret_empty_halt", 3'd5);
    checks++;
    if (halted !== 1'b1 || fault !== 1'b1) begin
      errors++;
      $display("FAIL ret_empty_flags: halted=%b fault=%b want 1/1", halted, fault);
    end
    sb_drain("ret_empty_drain");
    do_reset();
    checks++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_fault: halted=%b fault=%b want 0/0", halted, fault);
    end
  endtask

  task automatic test_halt_op();
    int n;
    start_run();
    fetch(16'h6000, 0, n);
    tick();
    chk_state("halt_op", 3'd5);
    checks++;
    if (halted !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL halt_op_flags: halted=%b fault=%b want 1/0", halted, fault);
    end
    sb_drain("halt_op_drain");
  endtask

  initial begin
    test_reset();
    test_nop();
    test_jmp();
    test_jz();
    test_call_ret();
    test_skip();
    test_ex();
    test_rst_fetch();
    test_stack_full();
    test_ret_empty();
    test_halt_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
